// File: rtl/fm_demod_pkg.sv
// Shared constants and types for the time-shared CORDIC FM demodulator.
//   NCH_MAX        : largest supported channel count
//   PW / PH_OFF    : phase width and its bit offset inside the core result word
//   DPHASE_LIM_*   : glitch-hold window on the per-sample phase step
//   ch_id_t        : channel ID wide enough for NCH_MAX channels
package fm_demod_pkg;
  localparam int NCH_MAX = 8;
  localparam int PW      = 24;
  localparam int PH_OFF  = 24;

  localparam logic [PW-1:0] DPHASE_LIM_POS = 24'h200000;
  localparam logic [PW-1:0] DPHASE_LIM_NEG = 24'hE00000;

  typedef logic [$clog2(NCH_MAX)-1:0] ch_id_t;
endpackage

// File: rtl/tag_fifo.sv
// In-flight channel-tag FIFO. Head entry is visible on rdata without a read
// latency so a core result can be matched to its channel in the same cycle.
//   push/wdata : enqueue (accepted when not full, or when popping the same cycle)
//   pop/rdata  : dequeue head (ignored when empty)
//   full/empty : occupancy flags
module tag_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNW = $clog2(DEPTH + 1);

  logic [W-1:0]   mem [DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNW-1:0] cnt_q;
  logic           do_push, do_pop;

  assign full    = (cnt_q == CNW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr_q];

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= inc(rd_ptr_q);
      if (do_push && !do_pop)      cnt_q <= cnt_q + CNW'(1);
      else if (do_pop && !do_push) cnt_q <= cnt_q - CNW'(1);
    end
  end

  // Storage needs no reset: entries are only read behind a valid count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/cordic_vec_sched.sv
// Shares one CORDIC vectoring core between NCH channels for FM demodulation.
// Round-robin arbiter -> registered core input with channel tag pushed to a
// FIFO; core results pop the FIFO, and a per-channel phase-difference stage
// with glitch hold produces the FM output.
//   clk, rst_n                 : clock, async active-low reset
//   ch_en, req_valid           : per-channel enable / sample valid
//   req_i, req_q               : packed signed I/Q, channel c at [c*DW +: DW]
//   req_ready                  : combinational one-hot grant
//   cor_tvalid, cor_tdata      : to core, {I24, Q24}
//   cor_out_tvalid/_tdata      : from core, phase in [47:24]
//   res_valid/res_ch/res_dphase: demodulated output
//   err_orphan                 : sticky, result seen with no tag in flight
module cordic_vec_sched
  import fm_demod_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int TAG_DEPTH = 32,
  parameter int DW        = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NCH-1:0]          ch_en,
  input  logic [NCH-1:0]          req_valid,
  input  logic [NCH*DW-1:0]       req_i,
  input  logic [NCH*DW-1:0]       req_q,
  output logic [NCH-1:0]          req_ready,
  output logic                    cor_tvalid,
  output logic [47:0]             cor_tdata,
  input  logic                    cor_out_tvalid,
  input  logic [47:0]             cor_out_tdata,
  output logic                    res_valid,
  output logic [$clog2(NCH)-1:0]  res_ch,
  output logic [PW-1:0]           res_dphase,
  output logic                    err_orphan
);
  localparam int CW = $clog2(NCH);

  // ---------------- arbiter ----------------
  logic [CW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [NCH-1:0] gnt;
  ch_id_t         gnt_id;
  logic           issue, fifo_full, fifo_empty, pop;
  logic [CW-1:0]  rch;

  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  always_comb begin
    int idx;
    idx    = 0;
    gnt    = '0;
    gnt_id = '0;
    if (rst_n && (!fifo_full || cor_out_tvalid)) begin
      // Walk offsets high to low so the nearest eligible channel wins.
      for (int k = NCH - 1; k >= 0; k--) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= NCH) idx = idx - NCH;
        if (req_valid[idx] && ch_en[idx]) begin
          gnt      = '0;
          gnt[idx] = 1'b1;
          gnt_id   = ch_id_t'(idx);
        end
      end
    end
  end

  assign req_ready = gnt;
  assign issue     = |gnt;
  assign rr_ptr_d  = !issue ? rr_ptr_q :
                     (int'(gnt_id) == NCH - 1) ? '0 : CW'(int'(gnt_id) + 1);

  // ---------------- issue register ----------------
  logic        cor_tvalid_q;
  logic [47:0] cor_tdata_q;
  logic [DW-1:0] sel_i, sel_q;

  assign sel_i = req_i[int'(gnt_id)*DW +: DW];
  assign sel_q = req_q[int'(gnt_id)*DW +: DW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q     <= '0;
      cor_tvalid_q <= 1'b0;
      cor_tdata_q  <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      cor_tvalid_q <= issue;
      if (issue) cor_tdata_q <= {PW'(signed'(sel_i)), PW'(signed'(sel_q))};
    end
  end

  assign cor_tvalid = cor_tvalid_q;
  assign cor_tdata  = cor_tdata_q;

  tag_fifo #(.W(CW), .DEPTH(TAG_DEPTH)) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (issue),
    .wdata (gnt_id[CW-1:0]),
    .pop   (pop),
    .rdata (rch),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ---------------- differencing ----------------
  logic [NCH-1:0][PW-1:0] prev_q, prev_d, last_d_q, last_d_d;
  logic [NCH-1:0]         primed_q, primed_d, ch_en_q, fall;
  logic [PW-1:0]          phase, dphase, res_dphase_d, res_dphase_q;
  logic                   glitch, primed_e;
  logic                   res_valid_q, err_orphan_q;
  logic [CW-1:0]          res_ch_q;
  logic                   unused_mag;

  assign unused_mag = ^cor_out_tdata[PH_OFF-1:0];
  assign pop   = cor_out_tvalid & ~fifo_empty;
  assign fall  = ch_en_q & ~ch_en;
  assign phase = cor_out_tdata[PH_OFF +: PW];

  // Flush is applied first so a coincident result for the same channel is
  // treated as the first sample after re-priming.
  always_comb begin
    prev_d       = prev_q;
    primed_d     = primed_q & ~fall;
    last_d_d     = last_d_q;
    for (int c = 0; c < NCH; c++)
      if (fall[c]) last_d_d[c] = '0;
    dphase       = phase - prev_q[rch];
    glitch       = ($signed(dphase) > $signed(DPHASE_LIM_POS)) ||
                   ($signed(dphase) < $signed(DPHASE_LIM_NEG));
    primed_e     = primed_d[rch];
    res_dphase_d = '0;
    if (pop) begin
      prev_d[rch]   = phase;
      primed_d[rch] = 1'b1;
      if (!primed_e)   res_dphase_d = '0;
      else if (glitch) res_dphase_d = last_d_d[rch];
      else begin
        res_dphase_d  = dphase;
        last_d_d[rch] = dphase;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q       <= '0;
      last_d_q     <= '0;
      primed_q     <= '0;
      ch_en_q      <= '0;
      res_valid_q  <= 1'b0;
      res_ch_q     <= '0;
      res_dphase_q <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      prev_q       <= prev_d;
      last_d_q     <= last_d_d;
      primed_q     <= primed_d;
      ch_en_q      <= ch_en;
      res_valid_q  <= pop;
      if (pop) begin
        res_ch_q     <= rch;
        res_dphase_q <= res_dphase_d;
      end
      if (cor_out_tvalid && fifo_empty) err_orphan_q <= 1'b1;
    end
  end

  assign res_valid  = res_valid_q;
  assign res_ch     = res_ch_q;
  assign res_dphase = res_dphase_q;
  assign err_orphan = err_orphan_q;
endmodule

// File: tb/tb_cordic_vec_sched.sv
module tb_cordic_vec_sched;
  localparam int NCH = 4, TAG_DEPTH = 8, DW = 16;

  logic              clk = 1'b0, rst_n = 1'b0;
  logic [NCH-1:0]    ch_en = '1, req_valid = '0, req_ready;
  logic [NCH*DW-1:0] req_i, req_q;
  logic              cor_tvalid, cor_out_tvalid = 1'b0;
  logic [47:0]       cor_tdata, cor_out_tdata = '0;
  logic              res_valid, err_orphan;
  logic [1:0]        res_ch;
  logic [23:0]       res_dphase;

  int checks = 0, failures = 0;
  int          tag_q[$];
  logic [31:0] exp_q[$];
  logic [15:0] si[NCH], sq[NCH];

  always #5 clk = ~clk;

  cordic_vec_sched #(.NCH(NCH), .TAG_DEPTH(TAG_DEPTH), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .ch_en(ch_en), .req_valid(req_valid),
    .req_i(req_i), .req_q(req_q), .req_ready(req_ready),
    .cor_tvalid(cor_tvalid), .cor_tdata(cor_tdata),
    .cor_out_tvalid(cor_out_tvalid), .cor_out_tdata(cor_out_tdata),
    .res_valid(res_valid), .res_ch(res_ch), .res_dphase(res_dphase),
    .err_orphan(err_orphan)
  );

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] tdata_of(input int ch);
    return {{8{si[ch][15]}}, si[ch], {8{sq[ch][15]}}, sq[ch]};
  endfunction

  // Single requester: grant must go to ch, sample appears next cycle.
  task automatic do_issue(input int ch);
    req_valid = NCH'(1) << ch;
    #1 chk("req_ready", 48'(req_ready), 48'(NCH'(1) << ch));
    tag_q.push_back(ch);
    @(negedge clk);
    req_valid = '0;
    chk("cor_tvalid", 48'(cor_tvalid), 48'd1);
    chk("cor_tdata", cor_tdata, tdata_of(ch));
  endtask

  // Bench acts as the core: returns one phase for the oldest issued tag.
  task automatic do_result(input logic [23:0] phase, input logic [23:0] exp_dp);
    int ch;
    logic [31:0] e;
    ch = tag_q.pop_front();
    exp_q.push_back({ch[7:0], exp_dp});
    cor_out_tvalid = 1'b1;
    cor_out_tdata  = {phase, 24'h0};
    @(negedge clk);
    cor_out_tvalid = 1'b0;
    e = exp_q.pop_front();
    chk("res_valid", 48'(res_valid), 48'd1);
    chk("res_ch", 48'(res_ch), 48'(e[31:24]));
    chk("res_dphase", 48'(res_dphase), 48'(e[23:0]));
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req_ready", 48'(req_ready), 48'd0);
    chk("rst_cor_tvalid", 48'(cor_tvalid), 48'd0);
    chk("rst_cor_tdata", cor_tdata, 48'd0);
    chk("rst_res_valid", 48'(res_valid), 48'd0);
    chk("rst_res_ch", 48'(res_ch), 48'd0);
    chk("rst_res_dphase", 48'(res_dphase), 48'd0);
    chk("rst_err_orphan", 48'(err_orphan), 48'd0);
  endtask

  initial begin
    int rr;
    logic [31:0] e;
    si[0] = 16'h8001; sq[0] = 16'h0002;
    si[1] = 16'h1234; sq[1] = 16'hC000;
    si[2] = 16'h7FFF; sq[2] = 16'h0100;
    si[3] = 16'hFFFF; sq[3] = 16'h0000;
    for (int c = 0; c < NCH; c++) begin
      req_i[c*DW +: DW] = si[c];
      req_q[c*DW +: DW] = sq[c];
    end

    // Reset state with all channels requesting
    req_valid = '1;
    #1 chk_reset_outputs();
    @(negedge clk); @(negedge clk);
    req_valid = '0;
    rst_n = 1'b1;
    @(negedge clk);

    // Single channel
    do_issue(0); do_issue(0); do_issue(0);
    do_result(24'h000000, 24'h000000);
    do_result(24'h010000, 24'h010000);
    do_result(24'h030000, 24'h020000);

    // Round robin until the FIFO fills (rr pointer now at 1)
    rr = 1;
    req_valid = '1;
    for (int k = 0; k < TAG_DEPTH; k++) begin
      #1 chk("rr_grant", 48'(req_ready), 48'(NCH'(1) << rr));
      tag_q.push_back(rr);
      @(negedge clk);
      chk("rr_cor_tvalid", 48'(cor_tvalid), 48'd1);
      chk("rr_cor_tdata", cor_tdata, tdata_of(rr));
      rr = (rr + 1) % NCH;
    end
    for (int k = 0; k < 2; k++) begin
      #1 chk("full_ready", 48'(req_ready), 48'd0);
      @(negedge clk);
      chk("full_cor_tvalid", 48'(cor_tvalid), 48'd0);
    end
    // Result while full: simultaneous pop and push
    cor_out_tvalid = 1'b1;
    cor_out_tdata  = {24'h7FF000, 24'h0};
    begin
      int ch;
      ch = tag_q.pop_front();
      exp_q.push_back({ch[7:0], 24'h000000});
    end
    #1 chk("full_pushpop_grant", 48'(req_ready), 48'(NCH'(1) << rr));
    tag_q.push_back(rr);
    @(negedge clk);
    cor_out_tvalid = 1'b0;
    e = exp_q.pop_front();
    chk("pp_res_valid", 48'(res_valid), 48'd1);
    chk("pp_res_ch", 48'(res_ch), 48'(e[31:24]));
    chk("pp_res_dphase", 48'(res_dphase), 48'(e[23:0]));
    chk("pp_cor_tvalid", 48'(cor_tvalid), 48'd1);
    chk("pp_cor_tdata", cor_tdata, tdata_of(rr));
    #1 chk("refull_ready", 48'(req_ready), 48'd0);
    req_valid = '0;
    @(negedge clk);

    // Drain: tags 2,3,0,1,2,3,0,1 -- boundaries, wrap and glitch hold
    do_result(24'h100000, 24'h000000);  // ch2 first
    do_result(24'h200000, 24'h000000);  // ch3 first
    do_result(24'h040000, 24'h010000);  // ch0
    do_result(24'h801000, 24'h002000);  // ch1 wrap accepted
    do_result(24'h300000, 24'h200000);  // ch2 +limit accepted
    do_result(24'h000000, 24'hE00000);  // ch3 -limit accepted
    do_result(24'h240001, 24'h010000);  // ch0 just over limit: hold
    do_result(24'h301000, 24'h002000);  // ch1 d=0xB00000: hold
    @(negedge clk);
    chk("idle_res_valid", 48'(res_valid), 48'd0);

    // Flush ch2 with a result in flight
    do_issue(2); do_issue(0);
    ch_en = 4'b1011;
    @(negedge clk);
    ch_en = 4'b1111;
    do_result(24'h310000, 24'h000000);  // ch2 re-primes
    do_result(24'h241000, 24'h000FFF);  // ch0 unaffected
    do_issue(2); do_issue(2); do_issue(2);
    do_result(24'h318000, 24'h008000);
    ch_en = 4'b1011;                    // flush coincident with result
    do_result(24'h320000, 24'h000000);
    ch_en = 4'b1111;
    do_result(24'h321000, 24'h001000);  // stayed primed

    // Orphan result
    chk("orphan_pre", 48'(err_orphan), 48'd0);
    cor_out_tvalid = 1'b1;
    cor_out_tdata  = {24'h123456, 24'h0};
    @(negedge clk);
    cor_out_tvalid = 1'b0;
    chk("orphan_set", 48'(err_orphan), 48'd1);
    chk("orphan_res_valid", 48'(res_valid), 48'd0);
    @(negedge clk); @(negedge clk);
    chk("orphan_sticky", 48'(err_orphan), 48'd1);

    // Mid-stream reset
    req_valid = '1;
    rst_n = 1'b0;
    #1 chk_reset_outputs();
    @(negedge clk);
    chk_reset_outputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cordic_vec_sched.md
# cordic_vec_sched

Time-shares one CORDIC vectoring (translate) core between `NCH` baseband channels that each need FM demodulation. Round-robin arbitration over per-channel I/Q requests issues one sample per cycle into the core, tags each issue with its channel ID, and re-associates core results with their channel. A per-channel phase-difference stage with glitch hold produces the demodulated FM output. The block sits between the channel DDC outputs and the audio/decimation back end, and replaces one CORDIC per channel.

## Interface
Parameters:
- `NCH`, 4, number of requesting channels (2..8)
- `TAG_DEPTH`, 32, depth of the in-flight tag FIFO; must be at least the core latency plus 2
- `DW`, 16, I/Q sample width

Ports (clock and reset are fixed: one clock; reset is asynchronous and active-low):
- `clk` in 1: sole clock
- `rst_n` in 1: asynchronous active-low reset
- `ch_en` in NCH: channel enable; a falling edge flushes that channel's phase history
- `req_valid` in NCH: per-channel sample valid
- `req_i` in NCH*DW: channel c I sample at `[c*DW +: DW]`, signed
- `req_q` in NCH*DW: channel c Q sample, same packing
- `req_ready` out NCH: one-hot or zero, combinational grant
- `cor_tvalid` out 1: sample valid to the core
- `cor_tdata` out 48: `{I24, Q24}`; each half is the sample sign-extended to 24 bits
- `cor_out_tvalid` in 1: core result valid
- `cor_out_tdata` in 48: core result; phase is `[47:24]`
- `res_valid` out 1: demodulated sample valid
- `res_ch` out clog2(NCH): channel of the result
- `res_dphase` out 24: signed phase difference (FM output)
- `err_orphan` out 1: sticky, set when a result arrives while the tag FIFO is empty

## Operation
- **Arbitration**
  - Eligible channels have `req_valid[c] & ch_en[c]`.
  - Grant goes to the first eligible channel at or after `rr_ptr`, wrapping.
  - No grant is made while the tag FIFO is full.
  - A transfer occurs when `req_valid[c] & req_ready[c]`. After a grant to c, `rr_ptr <= (c+1) mod NCH`.
- **Issue**
  - The granted sample is registered onto `cor_tvalid` / `cor_tdata`.
  - The channel ID is pushed into the tag FIFO in the same cycle.
  - `cor_tvalid` is low in any cycle without a grant.
- **Result association**
  - On `cor_out_tvalid`, pop the tag FIFO. The popped ID is the result channel.
  - If the FIFO is empty: set `err_orphan` and discard the result. Cleared only by reset.
  - A simultaneous push and pop while the FIFO is full is legal and leaves the count unchanged.
- **Differencing, per channel c** (registers `prev[c]`, `last_d[c]`, `primed[c]`)
  - d = phase − prev[c], taken mod 2^24.
  - If `!primed[c]`: output 0, then set `primed[c]`.
  - Else if signed d > 0x200000 or signed d < 0xE00000 (i.e. < −0x200000): output `last_d[c]` (glitch hold).
  - Otherwise output d and set `last_d[c] <= d`.
  - `prev[c] <= phase` in every case.
- **Flush**
  - A falling edge of `ch_en[c]` clears `primed[c]` and `last_d[c]`.
  - Tags already in flight for c are still delivered.
  - If a result for c arrives in the same cycle as its flush, the flush wins: the output is 0 and the channel stays primed afterwards.

## Timing
- Request transfer in cycle t → `cor_tvalid` in t+1.
- Core result in cycle u → `res_valid` / `res_ch` / `res_dphase` in u+1.
- Throughput is one sample per cycle in aggregate; per channel it is at least one per NCH cycles when all channels are requesting.
- Reset values:
  - `req_ready` = 0 while in reset.
  - `cor_tvalid`, `cor_tdata`, `res_valid`, `res_ch`, `res_dphase`, `err_orphan` = 0.
  - `rr_ptr` = 0; FIFO empty; all `prev`, `last_d`, `primed` = 0.
- Reset mid-stream drops all in-flight tags. Core results arriving after reset therefore raise `err_orphan`. The system resets the core together with this block.
- `req_i` / `req_q` must be stable while `req_valid` is high and not yet granted.

## Structure
- Package `fm_demod_pkg`:
  - `NCH_MAX`, phase width 24, phase field offset 24
  - `DPHASE_LIM_POS` = 24'h200000, `DPHASE_LIM_NEG` = 24'hE00000
  - channel ID typedef
- Sub-module `tag_fifo`: synchronous FIFO, width clog2(NCH), depth `TAG_DEPTH`, with full/empty flags.
- Arbiter, issue register and differencing stage live in the top level.

## Test plan
- **Single channel.** Ch0 only; phases 0x000000, 0x010000, 0x030000 → `res_dphase` 0, 0x010000, 0x020000 with `res_ch` = 0, each one cycle after the core result.
- **Round robin.** All four channels hold `req_valid` → grants in order 0, 1, 2, 3, 0, …. `cor_tvalid` is high every cycle and tags match on return.
- **Wrap and glitch.** Ch1 phases 0x7FF000, 0x801000 → d = 0x002000 is accepted. Next phase 0x301000 (d = 0xB00000) → `res_dphase` holds 0x002000.
- **Full FIFO.** Core stalled, `TAG_DEPTH` issues → `req_ready` goes to 0 and stays 0. The first core result gives a simultaneous push/pop and a grant resumes.
- **Flush.** Drop `ch_en[2]` mid-stream, then raise it again → the next ch2 result outputs 0 while other channels are unaffected.
- **Orphan / reset.** Assert `cor_out_tvalid` with the FIFO empty → `err_orphan` goes to 1 and stays 1 until `rst_n` is low. Then check that every output reads 0 during reset.
